// File: rtl/mv_sel_if.sv
// Handshake bundle between the SAD processing-element array and the
// motion-vector selector: candidate stream in, best vector and status out.
interface mv_sel_if #(
    parameter int SAD_WIDTH  = 16,
    parameter int RANGE_BITS = 4
);
    logic                         start;
    logic                         sad_valid;
    logic        [SAD_WIDTH-1:0]  sad_in;
    logic                         busy;
    logic                         done;
    logic signed [RANGE_BITS-1:0] mv_x;
    logic signed [RANGE_BITS-1:0] mv_y;
    logic        [SAD_WIDTH-1:0]  best_sad;

    modport master (
        output start, sad_valid, sad_in,
        input  busy, done, mv_x, mv_y, best_sad
    );

    modport slave (
        input  start, sad_valid, sad_in,
        output busy, done, mv_x, mv_y, best_sad
    );
endinterface

// File: rtl/mv_sel.sv
// Motion-vector selector: scans a raster-ordered stream of candidate SADs and
// reports the earliest minimum. Optional zero-vector bias under MV_SEL_ZERO_BIAS_EN.
module mv_sel #(
    parameter int SAD_WIDTH  = 16,
    parameter int RANGE_BITS = 4,
    parameter int ZERO_BIAS  = 64
) (
    input  logic    clk,
    input  logic    rst,
    mv_sel_if.slave bus
);
    localparam int                    IDX_W    = 2 * RANGE_BITS;
    localparam logic [IDX_W-1:0]      LAST_IDX = '1;
    localparam logic [RANGE_BITS-1:0] HALF     = RANGE_BITS'(1 << (RANGE_BITS - 1));
    localparam logic [SAD_WIDTH-1:0]  BIAS_V   = SAD_WIDTH'(ZERO_BIAS);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     cnt;
    logic [SAD_WIDTH-1:0] run_min;
    logic [IDX_W-1:0]     best_idx;

    logic [SAD_WIDTH-1:0] cand;
    logic                 take;
    logic [SAD_WIDTH-1:0] nxt_min;
    logic [IDX_W-1:0]     nxt_idx;

    // Zero-vector credit, saturating at zero so a small SAD never wraps high.
    function automatic logic [SAD_WIDTH-1:0] sat_bias(input logic [SAD_WIDTH-1:0] sad);
        return (sad > BIAS_V) ? (sad - BIAS_V) : '0;
    endfunction

`ifdef MV_SEL_ZERO_BIAS_EN
    localparam logic [IDX_W-1:0] ZERO_IDX =
        IDX_W'((1 << (IDX_W - 1)) + (1 << (RANGE_BITS - 1)));
`endif

    always_comb begin
`ifdef MV_SEL_ZERO_BIAS_EN
        cand = (cnt == ZERO_IDX) ? sat_bias(bus.sad_in) : bus.sad_in;
`else
        cand = bus.sad_in;
`endif
        // Strict less-than keeps the earliest index on ties.
        take    = cand < run_min;
        nxt_min = take ? cand : run_min;
        nxt_idx = take ? cnt : best_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            run_min      <= '1;
            best_idx     <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.mv_x     <= '0;
            bus.mv_y     <= '0;
            bus.best_sad <= '1;
        end else begin
            bus.done <= 1'b0;
            // start wins in every state: aborts a search, or re-arms from DONE.
            if (bus.start) begin
                state    <= SEARCH;
                cnt      <= '0;
                run_min  <= '1;
                best_idx <= '0;
                bus.busy <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    SEARCH: begin
                        if (bus.sad_valid) begin
                            run_min  <= nxt_min;
                            best_idx <= nxt_idx;
                            cnt      <= cnt + 1'b1;
                            if (cnt == LAST_IDX) begin
                                state        <= DONE;
                                bus.busy     <= 1'b0;
                                bus.done     <= 1'b1;
                                bus.best_sad <= nxt_min;
                                bus.mv_x     <= nxt_idx[RANGE_BITS-1:0] - HALF;
                                bus.mv_y     <= nxt_idx[IDX_W-1:RANGE_BITS] - HALF;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mv_sel.sv
// Bench for mv_sel: fixed vector table, abort/restart/reset sequences and
// randomized searches checked against an argmin model of the search window.
module tb_mv_sel;
    localparam int SW = 16;
    localparam int RB = 4;
    localparam int ZB = 64;
    localparam int W  = 1 << RB;
    localparam int N  = W * W;

`ifdef MV_SEL_ZERO_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mv_sel_if #(.SAD_WIDTH(SW), .RANGE_BITS(RB)) bif ();

    mv_sel #(.SAD_WIDTH(SW), .RANGE_BITS(RB), .ZERO_BIAS(ZB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        int base;
        int i1;
        int v1;
        int i2;
        int v2;
        int gap;
        int mx;
        int my;
        int sad;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   sads[N];
    vec_t vt[5];

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base, input int i1, input int v1, input int i2, input int v2);
        for (int i = 0; i < N; i++) sads[i] = base;
        if (i1 >= 0) sads[i1] = v1;
        if (i2 >= 0) sads[i2] = v2;
    endtask

    task automatic fill_rand(input int hi);
        for (int i = 0; i < N; i++) sads[i] = $urandom_range(hi, 0);
    endtask

    // Vector of candidate i is (x - W/2, y - W/2) with x = i % W, y = i / W.
    task automatic model(output int mx, output int my, output int sad);
        int eff[N];
        int mn;
        int first;
        mn = 1 << SW;
        first = 0;
        for (int i = 0; i < N; i++) begin
            eff[i] = sads[i];
            if (BIAS_EN && (i % W) == W / 2 && (i / W) == W / 2)
                eff[i] = (sads[i] > ZB) ? sads[i] - ZB : 0;
            if (eff[i] < mn) mn = eff[i];
        end
        for (int i = N - 1; i >= 0; i--)
            if (eff[i] == mn) first = i;
        mx  = (first % W) - W / 2;
        my  = (first / W) - W / 2;
        sad = mn;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, bif.busy, 0);
        chk({tag, "_done"}, bif.done, 0);
        chk({tag, "_mv_x"}, $signed(bif.mv_x), 0);
        chk({tag, "_mv_y"}, $signed(bif.mv_y), 0);
        chk({tag, "_best_sad"}, bif.best_sad, (1 << SW) - 1);
    endtask

    task automatic do_start();
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        chk("busy_after_start", bif.busy, 1);
        chk("done_after_start", bif.done, 0);
    endtask

    task automatic feed(input int n, input int gap_max, input bit final_batch);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            for (int k = 0; k < g; k++) begin
                bif.sad_valid = 1'b0;
                bif.sad_in    = SW'($urandom);
                tick();
                chk("busy_gap", bif.busy, 1);
                chk("done_gap", bif.done, 0);
            end
            bif.sad_valid = 1'b1;
            bif.sad_in    = SW'(sads[i]);
            tick();
            bif.sad_valid = 1'b0;
            if (i < n - 1 || !final_batch) begin
                chk("busy_mid", bif.busy, 1);
                chk("done_mid", bif.done, 0);
            end
        end
    endtask

    task automatic check_result(input string tag, input int mx, input int my, input int sad);
        chk({tag, "_done"}, bif.done, 1);
        chk({tag, "_busy"}, bif.busy, 0);
        chk({tag, "_mv_x"}, $signed(bif.mv_x), mx);
        chk({tag, "_mv_y"}, $signed(bif.mv_y), my);
        chk({tag, "_best_sad"}, bif.best_sad, sad);
    endtask

    task automatic post_done(input string tag, input int mx, input int my, input int sad);
        tick();
        chk({tag, "_done_drop"}, bif.done, 0);
        chk({tag, "_busy_idle"}, bif.busy, 0);
        chk({tag, "_mv_x_hold"}, $signed(bif.mv_x), mx);
        chk({tag, "_mv_y_hold"}, $signed(bif.mv_y), my);
        chk({tag, "_sad_hold"}, bif.best_sad, sad);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mx, my, sd, ndone;

        vt[0] = '{1000, 37, 5, -1, 0, 0, -3, -6, 5};
        vt[1] = BIAS_EN ? '{200, -1, 0, -1, 0, 0, 0, 0, 136}
                        : '{200, -1, 0, -1, 0, 0, -8, -8, 200};
        vt[2] = '{1000, 255, 9, -1, 0, 0, 7, 7, 9};
        vt[3] = BIAS_EN ? '{1000, 136, 100, 0, 50, 0, 0, 0, 36}
                        : '{1000, 136, 100, 0, 50, 0, -8, -8, 50};
        vt[4] = '{1000, 200, 0, -1, 0, 3, 0, 4, 0};

        rst = 1'b1;
        bif.start = 1'b0;
        bif.sad_valid = 1'b0;
        bif.sad_in = '0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        foreach (vt[r]) begin
            fill(vt[r].base, vt[r].i1, vt[r].v1, vt[r].i2, vt[r].v2);
            do_start();
            feed(N, vt[r].gap, 1'b1);
            check_result($sformatf("row%0d", r), vt[r].mx, vt[r].my, vt[r].sad);
            post_done($sformatf("row%0d", r), vt[r].mx, vt[r].my, vt[r].sad);
        end

        // sad_valid while idle must neither start nor disturb held results
        for (int k = 0; k < 6; k++) begin
            bif.sad_valid = 1'b1;
            bif.sad_in    = '0;
            tick();
            chk("idle_busy", bif.busy, 0);
            chk("idle_done", bif.done, 0);
        end
        bif.sad_valid = 1'b0;
        chk("idle_hold_sad", bif.best_sad, vt[4].sad);
        chk("idle_hold_mv_y", $signed(bif.mv_y), vt[4].my);

        // abort after 100 zero-valued candidates, then a full search
        fill(0, -1, 0, -1, 0);
        do_start();
        feed(100, 0, 1'b0);
        fill(1000, 255, 9, -1, 0);
        do_start();
        feed(N, 0, 1'b1);
        check_result("abort", 7, 7, 9);
        post_done("abort", 7, 7, 9);

        // start presented during the DONE cycle
        fill(1000, 37, 5, -1, 0);
        do_start();
        feed(N, 0, 1'b1);
        check_result("pre_restart", -3, -6, 5);
        do_start();
        fill(1000, 200, 3, -1, 0);
        feed(N, 1, 1'b1);
        check_result("restart_done", 0, 4, 3);
        post_done("restart_done", 0, 4, 3);

        // asynchronous reset in the middle of a search
        fill_rand(50);
        do_start();
        feed(50, 0, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 300; k++) begin
            bif.sad_valid = 1'($urandom);
            bif.sad_in    = SW'($urandom_range(10, 0));
            tick();
            if (bif.done === 1'b1) ndone++;
        end
        bif.sad_valid = 1'b0;
        chk("post_rst_done_count", ndone, 0);
        chk_reset_vals("post_rst");

        // randomized searches against the argmin model
        for (int r = 0; r < 6; r++) begin
            fill_rand((r % 2 == 0) ? 40 : 2000);
            model(mx, my, sd);
            do_start();
            feed(N, (r % 2 == 0) ? 0 : 2, 1'b1);
            check_result($sformatf("rand%0d", r), mx, my, sd);
            post_done($sformatf("rand%0d", r), mx, my, sd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
